bus_responder: RTL and testbench
================================

// Module: bus_responder
// PURPOSE
//  External-side memory/I-O target for the hmc-6502 chip bus: answers CPU reads,
//  commits CPU writes, and supplies the 6502 vectors. Holds a RAM region and a
//  memory-mapped byte port: a TX FIFO (CPU -> host) and an RX FIFO (host -> CPU),
//  each with valid/ready streams. Sits opposite the core on address/data/read_en;
//  the board or bench ties data_rd/data_oe onto the tristate data bus.
// PARAMETERS
//  RAM_AW      12        RAM address width; RAM spans 0x0000 .. 2**RAM_AW-1
//  IO_BASE     16'hF000  base of 4-byte I/O window (must not overlap RAM)
//  FIFO_AW     2         log2 depth of each FIFO (depth 4)
//  RESET_VEC   16'h0200  value returned for all vector pairs FFFA..FFFF
// PORTS
//  ph0       in   1   system clock; all state updates on rising edge
//  reset     in   1   synchronous, active-high reset
//  address   in   16  CPU address, valid for the whole bus cycle
//  read_en   in   1   1 = CPU read cycle, 0 = CPU write cycle
//  data_wr   in   8   CPU write data (valid when read_en=0)
//  data_rd   out  8   read data to CPU (combinational from address/state)
//  data_oe   out  1   responder drives data bus; = read_en & ~reset
//  tx_data   out  8   head of TX FIFO
//  tx_valid  out  1   TX FIFO non-empty
//  tx_ready  in   1   host accepts tx_data on edge where tx_valid&tx_ready
//  rx_data   in   8   host byte into RX FIFO
//  rx_valid  in   1   host offers rx_data
//  rx_ready  out  1   RX FIFO not full; push on edge where rx_valid&rx_ready
// BEHAVIOUR
//  - One bus cycle per ph0 period. Reads: data_rd settles combinationally in-cycle;
//    read side effects (RX pop) commit on the closing edge. Writes commit on the
//    closing edge when read_en=0.
//  - Map (priority top-down): FFFA-FFFF -> RESET_VEC (even addr = low byte, odd =
//    high); IO_BASE+0..3 -> I/O regs; RAM region -> RAM; else read 8'hFF, write dropped.
//  - RAM: async read, sync write; array is NOT cleared by reset.
//  - IO+0 TXDATA: write pushes data_wr to TX FIFO; read returns 8'h00.
//  - IO+1 RXDATA: read returns RX head and pops; empty -> returns 8'h00, no pop,
//    sets rx_underflow. Write ignored.
//  - IO+2 STATUS (read): {4'b0, rx_underflow, tx_overflow, rx_nonempty, tx_full}.
//    Write: bit2=1 clears tx_overflow, bit3=1 clears rx_underflow; others ignored.
//  - IO+3: reads 8'h00, writes ignored.
//  - FIFOs: FIFO_AW-bit pointers plus count (0..2**FIFO_AW); full = count==depth.
//    Pointers wrap modulo depth. Full/empty judged on state at start of cycle:
//    * TX push when full: dropped, tx_overflow set, even if host pops same edge.
//    * TX push and host pop same edge, not full: both occur, count unchanged.
//    * RX host push when full impossible (rx_ready=0). RX pop and host push same
//      edge: both occur; pop on empty with simultaneous push -> underflow, push kept.
//  - Sticky flags: set wins over clear on same edge.
//  - Reset (any cycle, incl. mid-stream): FIFO pointers/counts 0, tx_valid=0,
//    rx_ready=1, tx_overflow=rx_underflow=0, data_oe=0; pending write that
//    edge is discarded; tx_data value don't-care while tx_valid=0.
// TESTING
//  1 reset; read FFFC,FFFD -> 8'h00,8'h02; read 0x8000 -> 8'hFF; data_oe follows read_en.
//  2 write 0x0123<=8'hA5, write 0x0FFF<=8'h3C, read both -> A5, 3C; reset; reread -> A5, 3C.
//  3 tx_ready=0; write TXDATA 11,22,33,44 -> STATUS=8'h01; 5th write 55 -> STATUS=8'h05;
//    tx_ready=1 -> host sees 11,22,33,44 in order, 55 never appears; write STATUS 8'h04 -> 8'h00.
//  4 host pushes 8'hC7 -> STATUS bit1=1; read RXDATA -> C7; read again -> 00, STATUS=8'h08.
//  5 TX at count 3, push and host pop same edge -> count stays 3, order preserved;
//    RX empty, CPU pop and host push same edge -> underflow set, byte retained.
//  6 reset asserted while tx_valid=1 with 2 queued -> next cycle tx_valid=0, rx_ready=1, STATUS=00.

Source files
------------

// File: rtl/bus_responder.sv
// External-side target for the hmc-6502 chip bus: 6502 vectors, a RAM region, and a
// 4-byte I/O window exposing a CPU->host TX FIFO and a host->CPU RX FIFO.
module bus_responder #(
    parameter int unsigned RAM_AW    = 12,
    parameter logic [15:0] IO_BASE   = 16'hF000,
    parameter int unsigned FIFO_AW   = 2,
    parameter logic [15:0] RESET_VEC = 16'h0200
) (
    input  logic        ph0,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        read_en,
    input  logic [7:0]  data_wr,
    output logic [7:0]  data_rd,
    output logic        data_oe,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int unsigned     DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);
    localparam logic [15:0]     VEC_BASE = 16'hFFFA;

    logic [7:0]         ram_r [0:(1 << RAM_AW) - 1];
    logic [7:0]         tx_mem_r [0:DEPTH - 1];
    logic [7:0]         rx_mem_r [0:DEPTH - 1];

    logic [FIFO_AW-1:0] tx_wr_ptr_r, tx_rd_ptr_r, rx_wr_ptr_r, rx_rd_ptr_r;
    logic [FIFO_AW:0]   tx_count_r, rx_count_r;
    logic               tx_overflow_r, rx_underflow_r;

    logic [15:0]        io_diff_s;
    logic [1:0]         io_off_s;
    logic [RAM_AW-1:0]  ram_addr_s;
    logic               is_vec_s, is_io_s, is_ram_s;
    logic               wr_en_s, rd_en_s;
    logic               tx_full_s, tx_push_req_s, tx_push_s, tx_pop_s, tx_ovf_set_s, tx_ovf_clr_s;
    logic               rx_empty_s, rx_pop_req_s, rx_pop_s, rx_push_s, rx_udf_set_s, rx_udf_clr_s;
    logic               stat_wr_s;
    logic [7:0]         status_s;

    // Address decode, highest priority first: vectors, I/O window, RAM.
    always_comb begin
        io_diff_s = address - IO_BASE;
        is_vec_s  = (address >= VEC_BASE);
        is_io_s   = !is_vec_s && (io_diff_s < 16'd4);
        is_ram_s  = !is_vec_s && !is_io_s && ((address >> RAM_AW) == 16'd0);
    end

    assign io_off_s   = io_diff_s[1:0];
    assign ram_addr_s = address[RAM_AW-1:0];

    // Reset cancels any bus side effect pending on the same edge.
    assign wr_en_s = !read_en && !reset;
    assign rd_en_s = read_en && !reset;
    assign data_oe = read_en && !reset;

    assign tx_full_s     = (tx_count_r == DEPTH_C);
    assign tx_valid      = (tx_count_r != '0);
    assign tx_data       = tx_mem_r[tx_rd_ptr_r];
    assign tx_push_req_s = wr_en_s && is_io_s && (io_off_s == 2'd0);
    assign tx_push_s     = tx_push_req_s && !tx_full_s;
    assign tx_ovf_set_s  = tx_push_req_s && tx_full_s;
    assign tx_pop_s      = tx_valid && tx_ready;

    assign rx_empty_s    = (rx_count_r == '0);
    assign rx_ready      = (rx_count_r != DEPTH_C);
    assign rx_push_s     = rx_valid && rx_ready;
    assign rx_pop_req_s  = rd_en_s && is_io_s && (io_off_s == 2'd1);
    assign rx_pop_s      = rx_pop_req_s && !rx_empty_s;
    assign rx_udf_set_s  = rx_pop_req_s && rx_empty_s;

    assign stat_wr_s     = wr_en_s && is_io_s && (io_off_s == 2'd2);
    assign tx_ovf_clr_s  = stat_wr_s && data_wr[2];
    assign rx_udf_clr_s  = stat_wr_s && data_wr[3];

    assign status_s = {4'b0000, rx_underflow_r, tx_overflow_r, !rx_empty_s, tx_full_s};

    // Read data mux; unmapped addresses float high.
    always_comb begin
        data_rd = 8'hFF;
        if (is_vec_s) begin
            data_rd = address[0] ? RESET_VEC[15:8] : RESET_VEC[7:0];
        end else if (is_io_s) begin
            case (io_off_s)
                2'd1:    data_rd = rx_empty_s ? 8'h00 : rx_mem_r[rx_rd_ptr_r];
                2'd2:    data_rd = status_s;
                default: data_rd = 8'h00;
            endcase
        end else if (is_ram_s) begin
            data_rd = ram_r[ram_addr_s];
        end else begin
            data_rd = 8'hFF;
        end
    end

    // RAM contents survive reset by design.
    always_ff @(posedge ph0) begin
        if (wr_en_s && is_ram_s) begin
            ram_r[ram_addr_s] <= data_wr;
        end
    end

    // FIFO storage; only pointers and counts carry reset state.
    always_ff @(posedge ph0) begin
        if (tx_push_s) begin
            tx_mem_r[tx_wr_ptr_r] <= data_wr;
        end
        if (rx_push_s) begin
            rx_mem_r[rx_wr_ptr_r] <= rx_data;
        end
    end

    // FIFO pointers, counts and sticky error flags (set beats clear).
    always_ff @(posedge ph0) begin
        if (reset) begin
            tx_wr_ptr_r    <= '0;
            tx_rd_ptr_r    <= '0;
            tx_count_r     <= '0;
            rx_wr_ptr_r    <= '0;
            rx_rd_ptr_r    <= '0;
            rx_count_r     <= '0;
            tx_overflow_r  <= 1'b0;
            rx_underflow_r <= 1'b0;
        end else begin
            if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + FIFO_AW'(1);
            if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + FIFO_AW'(1);
            tx_count_r <= tx_count_r + (FIFO_AW + 1)'(tx_push_s) - (FIFO_AW + 1)'(tx_pop_s);

            if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + FIFO_AW'(1);
            if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + FIFO_AW'(1);
            rx_count_r <= rx_count_r + (FIFO_AW + 1)'(rx_push_s) - (FIFO_AW + 1)'(rx_pop_s);

            tx_overflow_r  <= tx_ovf_set_s || (tx_overflow_r && !tx_ovf_clr_s);
            rx_underflow_r <= rx_udf_set_s || (rx_underflow_r && !rx_udf_clr_s);
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: vectors, RAM, TX/RX FIFO paths, sticky flags, reset.
module tb_bus_responder;

    logic        ph0 = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic        read_en;
    logic [7:0]  data_wr;
    logic [7:0]  data_rd;
    logic        data_oe;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    int checks = 0;
    int errors = 0;

    localparam logic [15:0] IDLE_A = 16'h8000;
    localparam logic [15:0] TXD_A  = 16'hF000;
    localparam logic [15:0] RXD_A  = 16'hF001;
    localparam logic [15:0] STAT_A = 16'hF002;

    bus_responder dut (
        .ph0      (ph0),
        .reset    (reset),
        .address  (address),
        .read_en  (read_en),
        .data_wr  (data_wr),
        .data_rd  (data_rd),
        .data_oe  (data_oe),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

    always #5 ph0 = ~ph0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ph0);
        #1;
    endtask

    task automatic idle();
        address = IDLE_A;
        read_en = 1'b1;
        tick();
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string tag);
        address = a;
        read_en = 1'b1;
        #3;
        check(tag, {8'h00, data_rd}, {8'h00, exp});
        tick();
        address = IDLE_A;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        address = a;
        read_en = 1'b0;
        data_wr = d;
        tick();
        address = IDLE_A;
        read_en = 1'b1;
    endtask

    task automatic drain(input logic [7:0] exp[4], input string tag);
        tx_ready = 1'b1;
        address  = IDLE_A;
        read_en  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #3;
            check({tag, "_valid"}, {15'h0, tx_valid}, 16'h0001);
            check({tag, "_data"}, {8'h00, tx_data}, {8'h00, exp[i]});
            tick();
        end
        #3;
        check({tag, "_empty"}, {15'h0, tx_valid}, 16'h0000);
        tx_ready = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] q1[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] q2[4] = '{8'hBB, 8'hCC, 8'hDD, 8'hEE};

        reset = 1'b1; address = 16'hFFFC; read_en = 1'b1; data_wr = 8'h00;
        tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        tick();
        tick();
        // 1: reset state, vectors, unmapped read, data_oe
        check("rst_oe", {15'h0, data_oe}, 16'h0000);
        check("rst_tx_valid", {15'h0, tx_valid}, 16'h0000);
        check("rst_rx_ready", {15'h0, rx_ready}, 16'h0001);
        reset = 1'b0;
        #1;
        check("oe_read", {15'h0, data_oe}, 16'h0001);
        tick();
        rd(16'hFFFC, 8'h00, "vec_lo");
        rd(16'hFFFD, 8'h02, "vec_hi");
        rd(16'hFFFA, 8'h00, "vec_fffa");
        rd(16'hFFFF, 8'h02, "vec_ffff");
        rd(16'h8000, 8'hFF, "unmapped");
        read_en = 1'b0;
        #1;
        check("oe_write", {15'h0, data_oe}, 16'h0000);
        read_en = 1'b1;
        rd(STAT_A, 8'h00, "stat_init");

        // 2: RAM write/read, contents survive reset
        wr(16'h0123, 8'hA5);
        wr(16'h0FFF, 8'h3C);
        wr(16'h1000, 8'h77);
        rd(16'h0123, 8'hA5, "ram_0123");
        rd(16'h0FFF, 8'h3C, "ram_0fff");
        rd(16'h1000, 8'hFF, "ram_oob");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(16'h0123, 8'hA5, "ram_0123_rst");
        rd(16'h0FFF, 8'h3C, "ram_0fff_rst");

        // 3: TX fill, overflow, drain, clear
        wr(TXD_A, 8'h11);
        wr(TXD_A, 8'h22);
        wr(TXD_A, 8'h33);
        rd(STAT_A, 8'h00, "tx_3_notfull");
        wr(TXD_A, 8'h44);
        rd(STAT_A, 8'h01, "tx_full");
        rd(TXD_A, 8'h00, "txdata_read");
        wr(TXD_A, 8'h55);
        rd(STAT_A, 8'h05, "tx_overflow");
        drain(q1, "tx_drain1");
        rd(STAT_A, 8'h04, "tx_ovf_sticky");
        wr(STAT_A, 8'h04);
        rd(STAT_A, 8'h00, "tx_ovf_clr");

        // 4: RX single byte, underflow
        rx_valid = 1'b1; rx_data = 8'hC7;
        tick();
        rx_valid = 1'b0;
        rd(STAT_A, 8'h02, "rx_nonempty");
        rd(RXD_A, 8'hC7, "rx_pop");
        rd(RXD_A, 8'h00, "rx_empty_read");
        rd(STAT_A, 8'h08, "rx_underflow");
        wr(STAT_A, 8'h03);
        rd(STAT_A, 8'h08, "rx_udf_keep");
        wr(STAT_A, 8'h08);
        rd(STAT_A, 8'h00, "rx_udf_clr");

        // 5: simultaneous push/pop on TX at count 3
        wr(TXD_A, 8'hAA);
        wr(TXD_A, 8'hBB);
        wr(TXD_A, 8'hCC);
        address = TXD_A; read_en = 1'b0; data_wr = 8'hDD; tx_ready = 1'b1;
        #3;
        check("tx_same_head", {8'h00, tx_data}, 16'h00AA);
        tick();
        tx_ready = 1'b0; address = IDLE_A; read_en = 1'b1;
        rd(STAT_A, 8'h00, "tx_same_cnt3");
        wr(TXD_A, 8'hEE);
        rd(STAT_A, 8'h01, "tx_same_full");
        drain(q2, "tx_drain2");

        // 5: RX pop on empty while host pushes
        address = RXD_A; read_en = 1'b1; rx_valid = 1'b1; rx_data = 8'h5A;
        #3;
        check("rx_same_rd", {8'h00, data_rd}, 16'h0000);
        tick();
        rx_valid = 1'b0; address = IDLE_A;
        rd(STAT_A, 8'h0A, "rx_same_stat");
        rd(RXD_A, 8'h5A, "rx_same_kept");
        rd(STAT_A, 8'h08, "rx_same_empty");
        wr(STAT_A, 8'h08);

        // RX full: rx_ready drops, extra offer ignored
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1; rx_data = 8'(8'h30 + i);
            idle();
        end
        rx_data = 8'hFF;
        #3;
        check("rx_full_ready", {15'h0, rx_ready}, 16'h0000);
        idle();
        rx_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(RXD_A, 8'(8'h30 + i), "rx_full_order");
        end
        rd(STAT_A, 8'h00, "rx_full_drained");

        // 6: reset mid-stream with a write pending
        wr(TXD_A, 8'h01);
        wr(TXD_A, 8'h02);
        #3;
        check("pre_rst_valid", {15'h0, tx_valid}, 16'h0001);
        reset = 1'b1; address = TXD_A; read_en = 1'b0; data_wr = 8'h99;
        #1;
        check("rst_mid_oe", {15'h0, data_oe}, 16'h0000);
        tick();
        reset = 1'b0; address = IDLE_A; read_en = 1'b1;
        #3;
        check("post_rst_valid", {15'h0, tx_valid}, 16'h0000);
        check("post_rst_ready", {15'h0, rx_ready}, 16'h0001);
        tick();
        rd(STAT_A, 8'h00, "post_rst_stat");
        #3;
        check("post_rst_nowrite", {15'h0, tx_valid}, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
